pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve: load-use bubbles, branch-mispredict flushes, data-memory wait freezes and a debug halt/drain sequence. It drives the enable and flush strobes of the PC and every pipeline register, and keeps saturating stall/flush performance counters.

## Interface
- TIMEOUT_CYCLES, 255: consecutive memory-wait cycles after which mem_timeout is raised.
- CNT_WIDTH, 32: width of the performance counters.
- clk  in  1  pipeline clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_mispredict  in  1  the branch/jump in EX resolved against the prediction.
- dmem_req, dmem_ready  in  1 each  MEM-stage access pending / completed this cycle.
- id_valid, ex_valid, mem_valid, wb_valid  in  1 each  stage holds a real instruction.
- halt_req  in  1  debug halt request (level).
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (NOP, valid=0).
- halt_ack  out  1  registered; pipeline empty and held.
- mem_timeout  out  1  registered, sticky until rst.
- stall_cycles, flush_count  out  CNT_WIDTH each  saturating counters.

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- Strobes are combinational from the inputs and the current state. Default in RUN: all enables 1, all flushes 0.
- Per-cycle priority, highest first:
  1. rst: all enables 0, all flushes 1.
  2. Memory freeze (dmem_req && !dmem_ready): pc_en, if_id_en, id_ex_en and ex_mem_en are 0. mem_wb_en is 1 and mem_wb_flush is 1, so WB receives a bubble. All other flushes are 0.
  3. Mispredict (ex_mispredict): pc_en=1 to load the redirect target; if_id_flush=1 and id_ex_flush=1. A mispredict overrides a simultaneous load-use hazard because the ID instruction is on the wrong path.
  4. Load-use hazard: ex_mem_read, ex_rd!=0, and ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)). Response: pc_en=0, if_id_en=0, id_ex_flush=1. This gives exactly one bubble; the forwarding unit then supplies the data from WB.
- A mispredict that arrives during a freeze is not latched. EX is frozen, so ex_mispredict stays asserted and is applied in the first unfrozen cycle.
- RUN -> DRAIN when halt_req=1.
- In DRAIN:
  - pc_en=0 unless a mispredict is applied (the redirect is still captured).
  - if_id_en=1 with if_id_flush=1, so only bubbles enter.
  - Downstream stages advance normally under the priority rules above.
- DRAIN -> HALTED when id_valid, ex_valid, mem_valid and wb_valid are all 0 and there is no freeze.
- DRAIN -> RUN when halt_req drops first.
- In HALTED: all enables 0 and all flushes 0.
- HALTED -> RUN when halt_req=0.
- halt_ack is 1 exactly while the state register is HALTED.

## Timing
- Reset values: state RUN, halt_ack 0, mem_timeout 0, wait counter 0, both perf counters 0.
- All strobes are zero-latency, i.e. valid in the same cycle as their cause.
- halt_ack rises on the edge that enters HALTED and falls on the edge that leaves it.
- Wait counter:
  - Width is clog2(TIMEOUT_CYCLES+1).
  - It increments on every freeze cycle and clears on any non-freeze cycle.
  - On the edge where it would reach TIMEOUT_CYCLES, mem_timeout is set. The counter holds at TIMEOUT_CYCLES.
- stall_cycles increments on every cycle with pc_en=0 while the state is not HALTED (includes freeze, load-use and DRAIN cycles).
- flush_count increments once per cycle in which a mispredict flush is applied.
- Both counters saturate at all-ones and never wrap.
- rst asserted mid-DRAIN or mid-freeze returns everything to reset values on the next edge.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- Mispredict plus load-use in the same cycle: ex_mispredict=1 and a matching load hazard -> pc_en=1, if_id_flush=1, id_ex_flush=1; flush_count increments to 1; stall_cycles unchanged.
- Freeze: dmem_req=1, dmem_ready=0 for 3 cycles, with ex_mispredict=1 held throughout -> upstream enables 0 and mem_wb_flush=1 for 3 cycles; the flush is applied on cycle 4; stall_cycles=3.
- Timeout: TIMEOUT_CYCLES=4, freeze held for 6 cycles -> mem_timeout rises after the 4th freeze cycle and stays 1 after dmem_ready; it clears only on rst.
- Halt: halt_req=1 with all four stages valid -> DRAIN with pc_en=0 for 4 cycles as valids clear in order; then HALTED with halt_ack=1. Drop halt_req -> RUN next cycle, halt_ack=0.
- Counter saturation: CNT_WIDTH=4, 20 load-use stalls -> stall_cycles stops at 15. Asserting rst during DRAIN -> state RUN and both counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, mispredict, memory-wait freeze and debug halt.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_mispredict,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    input  logic                 id_valid,
    input  logic                 ex_valid,
    input  logic                 mem_valid,
    input  logic                 wb_valid,
    input  logic                 halt_req,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 mem_wb_flush,
    output logic                 halt_ack,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    state_t state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic timeout_q, timeout_d, halt_ack_q, halt_ack_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d, flush_q, flush_d;
    logic freeze, load_use, mp_apply, pipe_empty;
    assign freeze = dmem_req && !dmem_ready;
    assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                      ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    // A mispredict seen during a freeze stays asserted by the frozen EX stage, so it is simply deferred
    assign mp_apply = !rst && state_q != HALTED && !freeze && ex_mispredict;
    assign pipe_empty = !(id_valid || ex_valid || mem_valid || wb_valid);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_q     <= '0;
            timeout_q  <= 1'b0;
            halt_ack_q <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
            halt_ack_q <= halt_ack_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = halt_req ? DRAIN : RUN;
            DRAIN:   state_d = !halt_req ? RUN : (pipe_empty && !freeze) ? HALTED : DRAIN;
            HALTED:  state_d = halt_req ? HALTED : RUN;
            default: state_d = RUN;
        endcase
    end
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
            {if_id_flush, id_ex_flush, mem_wb_flush} = '1;
        end else if (state_q == HALTED) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
        end else if (freeze) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
            mem_wb_flush = 1'b1;
        end else begin
            if (mp_apply) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
            // While draining only bubbles enter IF/ID; a held load-use ID instruction is kept
            if (state_q == DRAIN) begin
                pc_en       = mp_apply;
                if_id_flush = if_id_en;
            end
        end
    end
    always_comb begin
        halt_ack_d = state_d == HALTED;
        wait_d     = !freeze ? '0 : (wait_q == WW'(TIMEOUT_CYCLES)) ? wait_q : wait_q + WW'(1);
        timeout_d  = timeout_q || (freeze && wait_q == WW'(TIMEOUT_CYCLES - 1));
        stall_d    = (!pc_en && state_q != HALTED && stall_q != '1) ? stall_q + CNT_WIDTH'(1) : stall_q;
        flush_d    = (mp_apply && flush_q != '1) ? flush_q + CNT_WIDTH'(1) : flush_q;
    end
    assign halt_ack     = halt_ack_q;
    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scenario tasks checking strobes through an expected-value queue plus registered state.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_mispredict, dmem_req, dmem_ready;
    logic id_valid, ex_valid, mem_valid, wb_valid, halt_req;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush;
    logic halt_ack, mem_timeout;
    logic [3:0] stall_cycles, flush_count;
    logic [7:0] strobes, exp_q[$];
    logic [9:0] regs;
    int checks = 0, errors = 0;
    localparam logic [7:0] S_RUN = 8'b11111_000, S_RST = 8'b00000_111, S_LU = 8'b00111_010;
    localparam logic [7:0] S_MP = 8'b11111_110, S_FRZ = 8'b00001_001, S_HALT = 8'b00000_000, S_DRAIN = 8'b01111_100;
    assign strobes = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush};
    assign regs = {halt_ack, mem_timeout, stall_cycles, flush_count};
    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mispredict(ex_mispredict),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .id_valid(id_valid), .ex_valid(ex_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid), .halt_req(halt_req), .pc_en(pc_en), .if_id_en(if_id_en),
        .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush), .halt_ack(halt_ack), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic set_idle();
        rst = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_mispredict = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1; halt_req = 1'b0;
        {id_valid, ex_valid, mem_valid, wb_valid} = 4'b1111;
    endtask

    task automatic do_reset();
        @(negedge clk); set_idle(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        @(negedge clk); set_idle(); rst = 1'b1; halt_req = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0; ex_mispredict = 1'b1;
        exp_q.push_back(S_RST); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL rst_strobes got=%b exp=%b", strobes, e); end
        @(negedge clk); set_idle();
        checks++; if (regs !== 10'b0) begin errors++; $display("FAIL rst_regs got=%b exp=%b", regs, 10'b0); end
        exp_q.push_back(S_RUN); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL run_default got=%b exp=%b", strobes, e); end
    endtask

    task automatic test_load_use();
        logic [7:0] e;
        do_reset();
        @(negedge clk); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        exp_q.push_back(S_LU); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL lu_rs1 got=%b exp=%b", strobes, e); end
        @(negedge clk);
        checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL lu_stall1 got=%0d exp=1", stall_cycles); end
        ex_rd = 5'd0; id_rs1 = 5'd0;
        exp_q.push_back(S_RUN); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL lu_x0 got=%b exp=%b", strobes, e); end
        @(negedge clk); ex_rd = 5'd7; id_uses_rs1 = 1'b0; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        exp_q.push_back(S_LU); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL lu_rs2 got=%b exp=%b", strobes, e); end
        @(negedge clk); id_uses_rs2 = 1'b0;
        exp_q.push_back(S_RUN); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL lu_unused got=%b exp=%b", strobes, e); end
        @(negedge clk); id_uses_rs2 = 1'b1; ex_mem_read = 1'b0;
        exp_q.push_back(S_RUN); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL lu_noload got=%b exp=%b", strobes, e); end
        @(negedge clk); set_idle();
        checks++; if (stall_cycles !== 4'd2) begin errors++; $display("FAIL lu_stall2 got=%0d exp=2", stall_cycles); end
    endtask

    task automatic test_mispredict();
        logic [7:0] e;
        do_reset();
        @(negedge clk); ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1; ex_mispredict = 1'b1;
        exp_q.push_back(S_MP); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL mp_over_lu got=%b exp=%b", strobes, e); end
        @(negedge clk); set_idle();
        checks++; if (regs !== {2'b00, 4'd0, 4'd1}) begin errors++; $display("FAIL mp_counts got=%b exp=%b", regs, {2'b00, 4'd0, 4'd1}); end
    endtask

    task automatic test_freeze();
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); dmem_req = 1'b1; dmem_ready = 1'b0; ex_mispredict = 1'b1;
            exp_q.push_back(S_FRZ); #1 e = exp_q.pop_front(); checks++;
            if (strobes !== e) begin errors++; $display("FAIL freeze%0d got=%b exp=%b", i, strobes, e); end
        end
        @(negedge clk); dmem_ready = 1'b1;
        exp_q.push_back(S_MP); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL freeze_release got=%b exp=%b", strobes, e); end
        @(negedge clk); set_idle();
        checks++; if (regs !== {2'b00, 4'd3, 4'd1}) begin errors++; $display("FAIL freeze_counts got=%b exp=%b", regs, {2'b00, 4'd3, 4'd1}); end
    endtask

    task automatic test_timeout();
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (mem_timeout !== (i >= 4)) begin errors++; $display("FAIL timeout_edge%0d got=%b exp=%b", i, mem_timeout, i >= 4); end
            dmem_req = 1'b1; dmem_ready = 1'b0;
            exp_q.push_back(S_FRZ); #1 e = exp_q.pop_front(); checks++;
            if (strobes !== e) begin errors++; $display("FAIL timeout_frz%0d got=%b exp=%b", i, strobes, e); end
        end
        @(negedge clk); dmem_ready = 1'b1;
        exp_q.push_back(S_RUN); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL timeout_ready got=%b exp=%b", strobes, e); end
        @(negedge clk); set_idle();
        checks++; if (regs !== {2'b01, 4'd6, 4'd0}) begin errors++; $display("FAIL timeout_sticky got=%b exp=%b", regs, {2'b01, 4'd6, 4'd0}); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b exp=0", mem_timeout); end
    endtask

    task automatic test_halt();
        logic [7:0] e;
        do_reset();
        @(negedge clk); halt_req = 1'b1;
        exp_q.push_back(S_RUN); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL halt_req_run got=%b exp=%b", strobes, e); end
        for (int d = 0; d < 4; d++) begin
            @(negedge clk); id_valid = 1'b0; ex_valid = d < 1; mem_valid = d < 2; wb_valid = d < 3;
            checks++; if (halt_ack !== 1'b0) begin errors++; $display("FAIL drain_ack%0d got=%b exp=0", d, halt_ack); end
            exp_q.push_back(S_DRAIN); #1 e = exp_q.pop_front(); checks++;
            if (strobes !== e) begin errors++; $display("FAIL drain%0d got=%b exp=%b", d, strobes, e); end
        end
        @(negedge clk);
        checks++; if (regs !== {2'b10, 4'd4, 4'd0}) begin errors++; $display("FAIL halted_regs got=%b exp=%b", regs, {2'b10, 4'd4, 4'd0}); end
        exp_q.push_back(S_HALT); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL halted got=%b exp=%b", strobes, e); end
        @(negedge clk); halt_req = 1'b0;
        exp_q.push_back(S_HALT); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL halted_release got=%b exp=%b", strobes, e); end
        @(negedge clk);
        checks++; if (regs !== {2'b00, 4'd4, 4'd0}) begin errors++; $display("FAIL resume_regs got=%b exp=%b", regs, {2'b00, 4'd4, 4'd0}); end
        halt_req = 1'b1;
        exp_q.push_back(S_RUN); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL resume got=%b exp=%b", strobes, e); end
        @(negedge clk); halt_req = 1'b0;
        exp_q.push_back(S_DRAIN); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL abort_drain got=%b exp=%b", strobes, e); end
        @(negedge clk);
        exp_q.push_back(S_RUN); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL abort_run got=%b exp=%b", strobes, e); end
    endtask

    task automatic test_saturation();
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
        end
        @(negedge clk); set_idle(); ex_mispredict = 1'b1;
        checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL stall_sat got=%0d exp=15", stall_cycles); end
        exp_q.push_back(S_MP); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL sat_mp got=%b exp=%b", strobes, e); end
        @(negedge clk); ex_mispredict = 1'b0; halt_req = 1'b1;
        @(negedge clk);
        exp_q.push_back(S_DRAIN); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL pre_rst_drain got=%b exp=%b", strobes, e); end
        @(negedge clk); rst = 1'b1;
        exp_q.push_back(S_RST); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL rst_in_drain got=%b exp=%b", strobes, e); end
        @(negedge clk); rst = 1'b0;
        checks++; if (regs !== 10'b0) begin errors++; $display("FAIL rst_drain_regs got=%b exp=%b", regs, 10'b0); end
        exp_q.push_back(S_RUN); #1 e = exp_q.pop_front(); checks++;
        if (strobes !== e) begin errors++; $display("FAIL rst_drain_run got=%b exp=%b", strobes, e); end
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_mispredict();
        test_freeze();
        test_timeout();
        test_halt();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
